// File: rtl/regfile_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_wport_arbiter_pkg
// Brief  : Shared register-file widths, types and helpers for the write port.
// Rev    : 1.0
// ============================================================================
package regfile_wport_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  localparam reg_idx_t REG_X0 = '0;

  typedef struct packed {
    logic     we;
    reg_idx_t waddr;
    xlen_t    wdata;
  } rf_wr_t;

  // x0 is hardwired zero, so a write aimed at it is not a real write.
  function automatic logic is_real_dest(input reg_idx_t rd);
    return rd != REG_X0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin pick among N requesters; pointer moves past the winner.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] pick_idx;
  logic [N-1:0]     masked;

  always_comb begin
    masked   = '0;
    grant    = '0;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr_q));
    end
    // Requesters at/after the pointer win first; otherwise wrap to the lowest.
    if (|masked) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (masked[i]) pick_idx = PTR_W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) pick_idx = PTR_W'(i);
      end
    end
    if (|req) grant[pick_idx] = 1'b1;

    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_wport_arbiter
// Brief  : Shares the regfile write port between pipeline writeback and
//          long-latency units, with a starvation-forced pipeline stall.
// Rev    : 1.0
// ============================================================================
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int STARVE_LIMIT = 8,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_we,
  input  logic [REG_IDX_W-1:0]         pipe_rd,
  input  logic [XLEN-1:0]              pipe_data,
  output logic                         pipe_stall,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [REG_IDX_W*NUM_REQ-1:0] req_rd,
  input  logic [XLEN*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rf_we,
  output logic [REG_IDX_W-1:0]         rf_waddr,
  output logic [XLEN-1:0]              rf_wdata
);

  logic               pipe_owns;
  logic               any_valid;
  logic               xfer;
  logic               blocked;
  logic [NUM_REQ-1:0] grant;
  reg_idx_t           sel_rd;
  xlen_t              sel_data;

  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               pipe_stall_q, pipe_stall_d;
  rf_wr_t             rf_q, rf_d;

  assign pipe_owns = pipe_we & is_real_dest(pipe_rd) & ~pipe_stall_q;
  assign any_valid = |req_valid;
  assign req_ready = pipe_owns ? '0 : grant;
  assign xfer      = |(req_valid & req_ready);
  assign blocked   = any_valid & pipe_owns;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  always_comb begin
    sel_rd   = REG_X0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_rd   = req_rd[REG_IDX_W*i +: REG_IDX_W];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // A stall cycle never counts as blocked, so the stall cannot repeat back to back.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (xfer || !any_valid) begin
      starve_cnt_d = '0;
    end else if (blocked && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    pipe_stall_d = blocked && (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1));
  end

  always_comb begin
    rf_d    = rf_q;
    rf_d.we = 1'b0;
    if (pipe_owns) begin
      rf_d = '{we: 1'b1, waddr: pipe_rd, wdata: pipe_data};
    end else if (xfer) begin
      rf_d = '{we: is_real_dest(sel_rd), waddr: sel_rd, wdata: sel_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      pipe_stall_q <= 1'b0;
      rf_q         <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
      rf_q         <= rf_d;
    end
  end

  assign pipe_stall = pipe_stall_q;
  assign rf_we      = rf_q.we;
  assign rf_waddr   = rf_q.waddr;
  assign rf_wdata   = rf_q.wdata;

endmodule
`default_nettype wire
